// File: rtl/vec_mem_pkg.sv
// Shared state encoding, requester IDs and defaults for the data-memory port arbiter.
package vec_mem_pkg;

   localparam int DEF_AW        = 16;
   localparam int DEF_DW        = 16;
   localparam int DEF_BURST_LEN = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      FIN    = 2'd3
   } arb_state_t;

   localparam logic [1:0] REQ_SCALAR = 2'd0;
   localparam logic [1:0] REQ_VLD    = 2'd1;
   localparam logic [1:0] REQ_VST    = 2'd2;

   function automatic logic [2:0] id_onehot(input logic [1:0] id);
      case (id)
         REQ_SCALAR: return 3'b001;
         REQ_VLD:    return 3'b010;
         REQ_VST:    return 3'b100;
         default:    return 3'b000;
      endcase
   endfunction

   // Successor in the 3-way ring; the unused code 3 folds back to 0.
   function automatic logic [1:0] rr_next(input logic [1:0] id);
      case (id)
         REQ_SCALAR: return REQ_VLD;
         REQ_VLD:    return REQ_VST;
         default:    return REQ_SCALAR;
      endcase
   endfunction

endpackage

// File: rtl/vec_arb_rr_pick.sv
// Combinational 3-way round-robin picker starting at ptr.
// VEC_ARB_SCALAR_PRIORITY_EN: the scalar requester wins whenever it is requesting.
module vec_arb_rr_pick
   import vec_mem_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] win,
   output logic [1:0] win_idx
);

   logic [1:0] c0;
   logic [1:0] c1;
   logic [1:0] c2;

   always_comb begin
      c0      = (ptr == 2'd3) ? REQ_SCALAR : ptr;
      c1      = rr_next(c0);
      c2      = rr_next(c1);
      win_idx = c0;
      if (req[c0])
         win_idx = c0;
      else if (req[c1])
         win_idx = c1;
      else if (req[c2])
         win_idx = c2;
`ifdef VEC_ARB_SCALAR_PRIORITY_EN
      if (req[REQ_SCALAR])
         win_idx = REQ_SCALAR;
`endif
      win = (|req) ? id_onehot(win_idx) : 3'b000;
   end

endmodule

// File: rtl/vec_mem_port_arbiter.sv
// Shares one data-memory port between scalar, vector-load and vector-store units.
// VEC_ARB_SCALAR_PRIORITY_EN: scalar requester always wins arbitration (see vec_arb_rr_pick).
module vec_mem_port_arbiter
   import vec_mem_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int RD_LAT    = 1
)(
   input  logic            Clk,
   input  logic            Rst,
   input  logic [2:0]      req,
   input  logic [2:0]      burst,
   input  logic [2:0]      wr_req,
   input  logic [3*AW-1:0] base_addr,
   input  logic [3*DW-1:0] wdata,
   output logic [2:0]      gnt,
   output logic [3:0]      beat_idx,
   output logic [DW-1:0]   rdata,
   output logic [2:0]      rvalid,
   output logic [2:0]      done,
   output logic [AW-1:0]   Addr,
   output logic            WR,
   output logic [DW-1:0]   DataIn,
   input  logic [DW-1:0]   DataOut
);

   localparam logic [3:0] LAST_BEAT  = 4'(BURST_LEN - 1);
   localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [1:0]        rr_ptr;
   logic [1:0]        owner;
   logic [1:0]        pick_idx;
   logic [2:0]        pick_win;
   logic              wr_l;
   logic [3:0]        last_beat;
   logic [2:0]        drain_cnt;
   logic [AW-1:0]     base_l;
   logic [AW-1:0]     addr_hold;
   logic [AW-1:0]     beat_addr;
   logic [AW-1:0]     pick_base;
   logic [DW-1:0]     owner_wdata;
   logic              grant;
   logic              beat_rd;
   logic [RD_LAT-1:0] ret_vld_p;
   logic [1:0]        ret_own_p [RD_LAT];

   vec_arb_rr_pick u_pick (
      .req     (req),
      .ptr     (rr_ptr),
      .win     (pick_win),
      .win_idx (pick_idx)
   );

   always_comb begin
      case (pick_idx)
         REQ_VLD: pick_base = base_addr[AW +: AW];
         REQ_VST: pick_base = base_addr[2*AW +: AW];
         default: pick_base = base_addr[0 +: AW];
      endcase
      case (owner)
         REQ_VLD: owner_wdata = wdata[DW +: DW];
         REQ_VST: owner_wdata = wdata[2*DW +: DW];
         default: owner_wdata = wdata[0 +: DW];
      endcase
   end

   assign beat_addr = base_l + AW'(beat_idx);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and port outputs; Addr keeps the last beat address outside ACTIVE.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      gnt       = 3'b000;
      done      = 3'b000;
      WR        = 1'b0;
      DataIn    = '0;
      beat_rd   = 1'b0;
      Addr      = addr_hold;
      case (state)
         IDLE: begin
            if (|req) begin
               grant     = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            gnt     = id_onehot(owner);
            Addr    = beat_addr;
            WR      = wr_l;
            DataIn  = wr_l ? owner_wdata : '0;
            beat_rd = ~wr_l;
            if (beat_idx == last_beat)
               state_nxt = wr_l ? FIN : DRAIN;
         end
         DRAIN: begin
            gnt = id_onehot(owner);
            if (drain_cnt == DRAIN_LAST)
               state_nxt = FIN;
         end
         FIN: begin
            gnt       = id_onehot(owner);
            done      = id_onehot(owner);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         owner     <= REQ_SCALAR;
         wr_l      <= 1'b0;
         last_beat <= 4'd0;
         beat_idx  <= 4'd0;
         drain_cnt <= 3'd0;
         rr_ptr    <= REQ_SCALAR;
         addr_hold <= '0;
      end else begin
         if (grant) begin
            owner     <= pick_idx;
            wr_l      <= |(wr_req & pick_win);
            last_beat <= (|(burst & pick_win)) ? LAST_BEAT : 4'd0;
            beat_idx  <= 4'd0;
         end
         if (state == ACTIVE) begin
            addr_hold <= beat_addr;
            drain_cnt <= 3'd0;
            if (beat_idx != last_beat)
               beat_idx <= beat_idx + 4'd1;
         end
         if (state == DRAIN)
            drain_cnt <= drain_cnt + 3'd1;
         if (state == FIN) begin
`ifdef VEC_ARB_SCALAR_PRIORITY_EN
            if (owner != REQ_SCALAR)
               rr_ptr <= rr_next(owner);
`else
            rr_ptr <= rr_next(owner);
`endif
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (grant)
         base_l <= pick_base;
   end

   // Read-return pipeline: one stage per cycle of memory latency
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ret_vld_p <= '0;
      end else begin
         ret_vld_p[0] <= beat_rd;
         for (int i = 1; i < RD_LAT; i++)
            ret_vld_p[i] <= ret_vld_p[i-1];
      end
   end

   always_ff @(posedge Clk) begin
      ret_own_p[0] <= owner;
      for (int i = 1; i < RD_LAT; i++)
         ret_own_p[i] <= ret_own_p[i-1];
   end

   assign rvalid = ret_vld_p[RD_LAT-1] ? id_onehot(ret_own_p[RD_LAT-1]) : 3'b000;
   assign rdata  = DataOut;

endmodule

// File: tb/tb_vec_mem_port_arbiter.sv
// Scoreboard bench for vec_mem_port_arbiter: expected grants, beats, returns and done pulses.
module tb_vec_mem_port_arbiter;

   localparam int RD_LAT = 1;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [2:0]  burst = 3'b000;
   logic [2:0]  wr_req = 3'b000;
   logic [47:0] base_addr = 48'h0;
   logic [47:0] wdata;
   logic [2:0]  gnt;
   logic [3:0]  beat_idx;
   logic [15:0] rdata;
   logic [2:0]  rvalid;
   logic [2:0]  done;
   logic [15:0] Addr;
   logic        WR;
   logic [15:0] DataIn;
   logic [15:0] DataOut;

   vec_mem_port_arbiter #(.RD_LAT(RD_LAT)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .req       (req),
      .burst     (burst),
      .wr_req    (wr_req),
      .base_addr (base_addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .beat_idx  (beat_idx),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .done      (done),
      .Addr      (Addr),
      .WR        (WR),
      .DataIn    (DataIn),
      .DataOut   (DataOut)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int          cyc;
      logic [2:0]  own;
      logic [15:0] a;
      logic [15:0] d;
   } exp_t;

   exp_t gq[$];
   exp_t wq[$];
   exp_t rq[$];
   exp_t dq[$];

   int cyc    = 0;
   int n_vec  = 0;
   int n_miss = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [15:0] wf(input int id, input logic [3:0] k);
      case (id)
         0:       return 16'hC000 | {12'h000, k};
         1:       return 16'h5000 | {12'h000, k};
         default: return {12'h000, k} * 16'h1111;
      endcase
   endfunction

   function automatic logic [15:0] mf(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C3C;
   endfunction

   assign wdata = {wf(2, beat_idx), wf(1, beat_idx), wf(0, beat_idx)};

   // Memory model: DataOut follows Addr by RD_LAT cycles.
   logic [15:0] mpipe [RD_LAT];
   always @(posedge Clk) begin
      mpipe[0] <= mf(Addr);
      for (int i = 1; i < RD_LAT; i++)
         mpipe[i] <= mpipe[i-1];
   end
   assign DataOut = mpipe[RD_LAT-1];

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic push_txn(input int own, input logic b, input logic w,
                           input logic [15:0] a, input int s, output int d);
      logic [2:0]  oh;
      logic [15:0] ak;
      int          len;
      oh  = 3'(1 << own);
      len = b ? 16 : 1;
      gq.push_back('{s, oh, 16'h0, 16'h0});
      for (int k = 0; k < len; k++) begin
         ak = a + 16'(k);
         if (w)
            wq.push_back('{s + k, oh, ak, wf(own, 4'(k))});
         else
            rq.push_back('{s + k + RD_LAT, oh, ak, mf(ak)});
      end
      d = s + len + (w ? 0 : RD_LAT);
      dq.push_back('{d, oh, 16'h0, 16'h0});
   endtask

   function automatic int pending();
      return gq.size() + wq.size() + rq.size() + dq.size();
   endfunction

   task automatic wait_empty(input int budget, input int re_cyc);
      int n = 0;
      while (pending() != 0 && n < budget) begin
         @(negedge Clk);
         #1;
         req = req & ~done;
         if (cyc == re_cyc)
            req[0] = 1'b1;
         n++;
      end
      chk_val("txn_complete", 32'(pending()), 32'd0);
   endtask

   task automatic run_single(input int own, input logic b, input logic w, input logic [15:0] a);
      int d;
      @(posedge Clk);
      #1;
      burst[own]                = b;
      wr_req[own]               = w;
      base_addr[own*16 +: 16]   = a;
      req[own]                  = 1'b1;
      push_txn(own, b, w, a, cyc + 1, d);
      wait_empty(100, -1);
   endtask

   task automatic chk_reset_outputs();
      chk_val("rst_gnt",    32'(gnt),      32'd0);
      chk_val("rst_done",   32'(done),     32'd0);
      chk_val("rst_wr",     32'(WR),       32'd0);
      chk_val("rst_addr",   32'(Addr),     32'd0);
      chk_val("rst_din",    32'(DataIn),   32'd0);
      chk_val("rst_rvalid", 32'(rvalid),   32'd0);
      chk_val("rst_beat",   32'(beat_idx), 32'd0);
   endtask

   // Monitor: pops the scoreboard on each observable DUT event.
   initial begin
      exp_t       e;
      logic [2:0] gnt_prev;
      gnt_prev = 3'b000;
      forever begin
         @(negedge Clk);
         chk_val("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
         if (gnt != 3'b000 && gnt_prev == 3'b000) begin
            if (gq.size() == 0) chk_val("gnt_unexp", 32'(gnt), 32'd0);
            else begin
               e = gq.pop_front();
               chk_val("gnt_cyc", 32'(cyc), 32'(e.cyc));
               chk_val("gnt_own", 32'(gnt), 32'(e.own));
            end
         end
         gnt_prev = gnt;
         if (WR) begin
            if (wq.size() == 0) chk_val("wr_unexp", 32'(WR), 32'd0);
            else begin
               e = wq.pop_front();
               chk_val("wr_cyc",  32'(cyc),    32'(e.cyc));
               chk_val("wr_own",  32'(gnt),    32'(e.own));
               chk_val("wr_addr", 32'(Addr),   32'(e.a));
               chk_val("wr_data", 32'(DataIn), 32'(e.d));
            end
         end else begin
            chk_val("din_idle", 32'(DataIn), 32'd0);
         end
         if (rvalid != 3'b000) begin
            if (rq.size() == 0) chk_val("rv_unexp", 32'(rvalid), 32'd0);
            else begin
               e = rq.pop_front();
               chk_val("rd_cyc",  32'(cyc),    32'(e.cyc));
               chk_val("rd_own",  32'(rvalid), 32'(e.own));
               chk_val("rd_data", 32'(rdata),  32'(e.d));
            end
         end
         if (done != 3'b000) begin
            if (dq.size() == 0) chk_val("done_unexp", 32'(done), 32'd0);
            else begin
               e = dq.pop_front();
               chk_val("done_cyc", 32'(cyc),  32'(e.cyc));
               chk_val("done_own", 32'(done), 32'(e.own));
               chk_val("done_gnt", 32'(gnt),  32'(e.own));
            end
         end
      end
   end

   initial begin
      int d0, d1, d2, d3;
      // Contention from reset: all three requesting while Rst is high.
      burst     = 3'b110;
      wr_req    = 3'b101;
      base_addr = {16'h0300, 16'h0200, 16'h0010};
      req       = 3'b111;
      repeat (2) @(posedge Clk);
      #1;
      chk_reset_outputs();
      Rst = 1'b0;
      push_txn(0, 1'b0, 1'b1, 16'h0010, cyc + 1, d0);
      push_txn(1, 1'b1, 1'b0, 16'h0200, d0 + 2, d1);
`ifdef VEC_ARB_SCALAR_PRIORITY_EN
      push_txn(0, 1'b0, 1'b1, 16'h0010, d1 + 2, d2);
      push_txn(2, 1'b1, 1'b1, 16'h0300, d2 + 2, d3);
`else
      push_txn(2, 1'b1, 1'b1, 16'h0300, d1 + 2, d2);
      push_txn(0, 1'b0, 1'b1, 16'h0010, d2 + 2, d3);
`endif
      wait_empty(300, d0 + 6);

      run_single(2, 1'b1, 1'b1, 16'h0100);
      run_single(1, 1'b1, 1'b0, 16'hFFF8);
      run_single(0, 1'b0, 1'b0, 16'h0042);

      // Reset during beat 7 of a vector store.
      @(posedge Clk);
      #1;
      burst[2]           = 1'b1;
      wr_req[2]          = 1'b1;
      base_addr[32 +: 16] = 16'h0400;
      req                = 3'b100;
      push_txn(2, 1'b1, 1'b1, 16'h0400, cyc + 1, d0);
      repeat (8) @(posedge Clk);
      #1;
      Rst = 1'b1;
      #1;
      chk_reset_outputs();
      chk_val("abort_beats_left", 32'(wq.size()), 32'd9);
      chk_val("abort_done_left",  32'(dq.size()), 32'd1);
      wq.delete();
      dq.delete();
      req                 = 3'b010;
      burst[1]            = 1'b1;
      wr_req[1]           = 1'b0;
      base_addr[16 +: 16] = 16'h0500;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      push_txn(1, 1'b1, 1'b0, 16'h0500, cyc + 1, d1);
      wait_empty(100, -1);

      for (int i = 0; i < 4; i++)
         run_single(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 16'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
